// File: rtl/ide_xfer_sequencer.sv
// IDE transfer sequencer: stages each 512-byte chunk from the SD card into the sector buffer,
// then hands it to the host by PIO or DMA through the IDE register write port.
`timescale 1ns/1ps
module ide_xfer_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  STATUS_DRQ     = 8'h58,
    parameter logic [7:0]  STATUS_DONE    = 8'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] chunk_count,
    input  logic       use_dma,
    input  logic       abort,
    output logic       sd_req,
    input  logic       sdcard_dma_strobe,
    input  logic [8:0] sdcard_dma_addr,
    input  logic       data_flag,
    output logic       reg_we,
    output logic [3:0] reg_a,
    output logic [7:0] reg_d,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StClr,
        StFillMode,
        StFillReq,
        StFillWait,
        StArmPos,
        StArmTgt,
        StArmCtrl,
        StArmStat,
        StXferWait,
        StAck,
        StFinCtrl,
        StFinStat,
        StErrCtrl,
        StErrErr,
        StErrStat
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  remain_q, remain_d;
    logic        dma_q, dma_d;
    logic [15:0] tmo_q, tmo_d;
    logic        reg_we_q, reg_we_d;
    logic [3:0]  reg_a_q, reg_a_d;
    logic [7:0]  reg_d_q, reg_d_d;
    logic        sd_req_q, sd_req_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        dma_d    = dma_q;
        tmo_d    = tmo_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = 1'b0;
                    if (chunk_count == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        remain_d = chunk_count;
                        dma_d    = use_dma;
                        state_d  = StClr;
                    end
                end
            end
            StClr:      state_d = StFillMode;
            StFillMode: state_d = StFillReq;
            StFillReq: begin
                state_d = StFillWait;
                tmo_d   = 16'd0;
            end
            StFillWait: begin
                if (sdcard_dma_strobe && sdcard_dma_addr == 9'h1FF) begin
                    state_d = StArmPos;
                end else if (tmo_q >= TmoLast) begin
                    state_d = StErrCtrl;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StArmPos:  state_d = StArmTgt;
            StArmTgt:  state_d = StArmCtrl;
            StArmCtrl: state_d = StArmStat;
            StArmStat: begin
                state_d = StXferWait;
                tmo_d   = 16'd0;
            end
            StXferWait: begin
                if (data_flag) begin
                    state_d = StAck;
                end else if (tmo_q >= TmoLast) begin
                    state_d = StErrCtrl;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            StAck: begin
                remain_d = remain_q - 8'd1;
                state_d  = (remain_d != 8'd0) ? StFillMode : StFinCtrl;
            end
            StFinCtrl: state_d = StFinStat;
            StFinStat: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            StErrCtrl: state_d = StErrErr;
            StErrErr:  state_d = StErrStat;
            StErrStat: begin
                state_d = StIdle;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any completion condition seen in the same cycle.
        if (abort && !(state_q inside {StIdle, StErrCtrl, StErrErr, StErrStat})) begin
            state_d = StErrCtrl;
            done_d  = 1'b0;
        end

        // Outputs are decoded from the next state so each write lines up with its state.
        reg_we_d = 1'b0;
        reg_a_d  = 4'd0;
        reg_d_d  = 8'd0;
        sd_req_d = 1'b0;
        case (state_d)
            StClr, StAck: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd6;
                reg_d_d  = 8'h20;
            end
            StFillMode: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd2;
                reg_d_d  = 8'h08;
            end
            StFillReq: sd_req_d = 1'b1;
            StArmPos: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd3;
                reg_d_d  = 8'h00;
            end
            StArmTgt: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd5;
                reg_d_d  = 8'hFF;
            end
            StArmCtrl: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd2;
                reg_d_d  = {4'b0000, 1'b1, dma_d, ~dma_d, 1'b0};
            end
            StArmStat: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd0;
                reg_d_d  = STATUS_DRQ;
            end
            StFinCtrl, StErrCtrl: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd2;
                reg_d_d  = 8'h00;
            end
            StFinStat: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd0;
                reg_d_d  = STATUS_DONE;
            end
            StErrErr: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd1;
                reg_d_d  = 8'h04;
            end
            StErrStat: begin
                reg_we_d = 1'b1;
                reg_a_d  = 4'd0;
                reg_d_d  = 8'h51;
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            remain_q <= 8'd0;
            dma_q    <= 1'b0;
            tmo_q    <= 16'd0;
            reg_we_q <= 1'b0;
            reg_a_q  <= 4'd0;
            reg_d_q  <= 8'd0;
            sd_req_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            dma_q    <= dma_d;
            tmo_q    <= tmo_d;
            reg_we_q <= reg_we_d;
            reg_a_q  <= reg_a_d;
            reg_d_q  <= reg_d_d;
            sd_req_q <= sd_req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign reg_we = reg_we_q;
    assign reg_a  = reg_a_q;
    assign reg_d  = reg_d_q;
    assign sd_req = sd_req_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
